// File: rtl/apx_int_add_acc.sv
// Frame accumulator for approximate adder results: LSB truncation, wide sum, valid/ready output.
// Optional APX_ACC_SAT_EN: saturate the accumulator to all-ones on carry out instead of wrapping.
module apx_int_add_acc #(
  parameter int BWOP  = 32,
  parameter int BWACC = 40,
  parameter int CNTW  = 8,
  parameter int TRW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BWOP-1:0]  in_data,
  input  logic [CNTW-1:0]  cfg_len,
  input  logic [TRW-1:0]   cfg_trunc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BWACC-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [BWACC-1:0]  acc_q, acc_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [CNTW-1:0]   len_q, len_d;
  logic [TRW-1:0]    trunc_q, trunc_d;
  logic [BWACC-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic              beat;
  logic              first;
  logic [CNTW-1:0]   len_use;
  logic [CNTW-1:0]   eff_len;
  logic [TRW-1:0]    trunc_use;
  logic [BWACC-1:0]  td;
  logic [BWACC:0]    sum;
  logic              ovf_new;
  logic [BWACC-1:0]  acc_new;
  logic [CNTW:0]     count_inc;
  logic              last;

  function automatic logic [BWOP-1:0] trunc_fn(input logic [BWOP-1:0] d,
                                               input logic [TRW-1:0]  t);
    logic [BWOP-1:0] mask;
    mask = '1;
    if (int'(t) >= BWOP) return '0;
    mask = mask << t;
    return d & mask;
  endfunction

`ifdef APX_ACC_SAT_EN
  function automatic logic [BWACC-1:0] sat_fn(input logic [BWACC:0] s, input logic o);
    return o ? '1 : s[BWACC-1:0];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      len_q      <= '0;
      trunc_q    <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  // The first beat of a frame uses the live config; later beats use the latched copy.
  always_comb begin
    beat      = in_valid && (state_q == ST_ACC);
    first     = (count_q == '0);
    len_use   = first ? cfg_len : len_q;
    trunc_use = first ? cfg_trunc : trunc_q;
    eff_len   = (len_use == '0) ? CNTW'(1) : len_use;
    td        = BWACC'(trunc_fn(in_data, trunc_use));
    sum       = {1'b0, acc_q} + {1'b0, td};
    ovf_new   = ovf_q | sum[BWACC];
`ifdef APX_ACC_SAT_EN
    acc_new   = sat_fn(sum, ovf_new);
`else
    acc_new   = sum[BWACC-1:0];
`endif
    count_inc = {1'b0, count_q} + {{CNTW{1'b0}}, 1'b1};
    last      = (count_inc == {1'b0, eff_len});

    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    if (beat) begin
      if (first) begin
        len_d   = cfg_len;
        trunc_d = cfg_trunc;
      end
      if (last) begin
        out_data_d = acc_new;
        out_ovf_d  = ovf_new;
        acc_d      = '0;
        count_d    = '0;
        ovf_d      = 1'b0;
        state_d    = ST_OUT;
      end else begin
        acc_d   = acc_new;
        ovf_d   = ovf_new;
        count_d = count_inc[CNTW-1:0];
      end
    end

    if (state_q == ST_OUT && out_ready) state_d = ST_ACC;
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_OUT);
    busy      = (state_q == ST_OUT) || (count_q != '0);
    out_data  = out_data_q;
    out_ovf   = out_ovf_q;
  end

endmodule

// File: tb/tb_apx_int_add_acc.sv
// Scoreboard bench for apx_int_add_acc: default 32/40 instance plus an 8/8 instance for carry cases.
module tb_apx_int_add_acc;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
  logic [31:0] in_data;
  logic [7:0]  cfg_len;
  logic [5:0]  cfg_trunc;
  logic [39:0] out_data;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf, s_busy;
  logic [7:0]  s_in_data;
  logic [7:0]  s_cfg_len;
  logic [5:0]  s_cfg_trunc;
  logic [7:0]  s_out_data;

  int checks = 0;
  int errors = 0;

  logic [40:0] exp_q[$];
  logic [8:0]  s_exp_q[$];
  logic [40:0] me;
  logic [8:0]  se;

  always #5 clk = ~clk;

  apx_int_add_acc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_len(cfg_len), .cfg_trunc(cfg_trunc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );

  apx_int_add_acc #(.BWOP(8), .BWACC(8), .CNTW(8), .TRW(6)) sdut (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .cfg_len(s_cfg_len), .cfg_trunc(s_cfg_trunc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected: got 0x%0h required no output", out_data);
      end else begin
        me = exp_q.pop_front();
        chk("main_data", 64'(out_data), 64'(me[39:0]));
        chk("main_ovf", 64'(out_ovf), 64'(me[40]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected: got 0x%0h required no output", s_out_data);
      end else begin
        se = s_exp_q.pop_front();
        chk("small_data", 64'(s_out_data), 64'(se[7:0]));
        chk("small_ovf", 64'(s_out_ovf), 64'(se[8]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a beat and return #1 after the edge that accepted it; in_valid is left high.
  task automatic beat(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL main_beat_timeout: in_ready got 0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic sbeat(input logic [7:0] d);
    int n = 0;
    s_in_valid = 1'b1;
    s_in_data  = d;
    while (!s_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!s_in_ready) begin
      checks++; errors++;
      $display("FAIL small_beat_timeout: in_ready got 0 required 1");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; cfg_len = '0; cfg_trunc = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_cfg_len = '0; s_cfg_trunc = '0; s_out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);

    // Four beats, output held under backpressure until out_ready rises
    out_ready = 1'b0;
    cfg_len = 8'd4; cfg_trunc = 6'd0;
    exp_q.push_back({1'b0, 40'd10});
    beat(32'd1); beat(32'd2); beat(32'd3);
    chk("t1_no_early_valid", 64'(out_valid), 64'd0);
    chk("t1_busy_mid", 64'(busy), 64'd1);
    beat(32'd4);
    in_valid = 1'b0;
    chk("t1_valid_latency", 64'(out_valid), 64'd1);
    chk("t1_in_ready_low", 64'(in_ready), 64'd0);
    idle(2);
    chk("t1_in_ready_held", 64'(in_ready), 64'd0);
    chk("t1_data_held", 64'(out_data), 64'd10);
    out_ready = 1'b1;
    idle(1);
    chk("t1_in_ready_back", 64'(in_ready), 64'd1);
    chk("t1_busy_clear", 64'(busy), 64'd0);

    // Truncation latched on the first beat; mid-frame change ignored
    cfg_len = 8'd2; cfg_trunc = 6'd4;
    exp_q.push_back({1'b0, 40'h30});
    beat(32'h1F);
    cfg_trunc = 6'd0;
    beat(32'h2F);
    in_valid = 1'b0;
    idle(2);

    // Zero length behaves as one
    cfg_len = 8'd0; cfg_trunc = 6'd0;
    exp_q.push_back({1'b0, 40'd7});
    beat(32'd7);
    in_valid = 1'b0;
    chk("t3_valid_latency", 64'(out_valid), 64'd1);
    idle(2);

    // Truncation boundaries: 31 bits cleared, then amount beyond operand width
    cfg_len = 8'd1; cfg_trunc = 6'd31;
    exp_q.push_back({1'b0, 40'h80000000});
    beat(32'hFFFFFFFF);
    in_valid = 1'b0;
    idle(2);
    cfg_trunc = 6'd40;
    exp_q.push_back({1'b0, 40'h0});
    beat(32'hFFFFFFFF);
    in_valid = 1'b0;
    idle(2);

    // Long backpressure with input pending, then fresh frame from zero
    out_ready = 1'b0;
    cfg_len = 8'd1; cfg_trunc = 6'd0;
    exp_q.push_back({1'b0, 40'd5});
    beat(32'd5);
    in_data = 32'd9;
    for (int i = 0; i < 5; i++) begin
      chk("t5_data_stable", 64'(out_data), 64'd5);
      chk("t5_no_accept", 64'(in_ready), 64'd0);
      idle(1);
    end
    exp_q.push_back({1'b0, 40'd9});
    out_ready = 1'b1;
    beat(32'd9);
    in_valid = 1'b0;
    idle(2);

    // Reset mid-frame discards the partial sum
    cfg_len = 8'd4;
    beat(32'd1); beat(32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    chk("t6_out_ovf", 64'(out_ovf), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 40'd4});
    for (int i = 0; i < 4; i++) beat(32'd1);
    in_valid = 1'b0;
    idle(2);

    // 8-bit instance: carry out, ovf clears per frame, sticky saturation across a frame
    s_cfg_len = 8'd2; s_cfg_trunc = 6'd0;
`ifdef APX_ACC_SAT_EN
    s_exp_q.push_back({1'b1, 8'hFF});
`else
    s_exp_q.push_back({1'b1, 8'h10});
`endif
    sbeat(8'hF0); sbeat(8'h20);
    s_in_valid = 1'b0;
    idle(2);
    s_exp_q.push_back({1'b0, 8'h03});
    sbeat(8'h01); sbeat(8'h02);
    s_in_valid = 1'b0;
    idle(2);
    s_cfg_len = 8'd3;
`ifdef APX_ACC_SAT_EN
    s_exp_q.push_back({1'b1, 8'hFF});
`else
    s_exp_q.push_back({1'b1, 8'h11});
`endif
    sbeat(8'hF0); sbeat(8'h20); sbeat(8'h01);
    s_in_valid = 1'b0;
    idle(2);

    for (int n = 0; n < 50 && (exp_q.size() != 0 || s_exp_q.size() != 0); n++) idle(1);
    chk("drain_main", 64'(exp_q.size()), 64'd0);
    chk("drain_small", 64'(s_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
